// File: rtl/kb_pkg.sv
// kb_pkg: shared FSM encoding, scan-code and ASCII constants for the keyboard reader
package kb_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XLATE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, XLATE = ST_XLATE, HOLD = ST_HOLD} state_t;
  localparam logic [7:0] SC_CAPS     = 8'h58;
  localparam logic [7:0] SC_ENTER    = 8'h5A;
  localparam logic [7:0] SC_BKSP     = 8'h66;
  localparam logic [7:0] SC_SPACE    = 8'h29;
  localparam logic [7:0] CR          = 8'h0D;
  localparam logic [7:0] BS          = 8'h08;
  localparam logic [7:0] SP          = 8'h20;
  localparam logic [7:0] CASE_OFFSET = 8'h20;
endpackage

// File: rtl/kb_scan2ascii.sv
// kb_scan2ascii: combinational PS/2 set-2 scan code to ASCII translation with caps handling
module kb_scan2ascii
  import kb_pkg::*;
(
  input  logic [7:0] code,
  input  logic       caps,
  output logic [7:0] ascii,
  output logic       is_mapped,
  output logic       is_letter
);
  logic [7:0] lower;
  // lower-case lookup; letters are flagged so caps can shift them
  always_comb begin
    lower = 8'h00;
    is_letter = 1'b0;
    is_mapped = 1'b1;
    case (code)
      8'h1C: {is_letter, lower} = {1'b1, 8'h61};
      8'h32: {is_letter, lower} = {1'b1, 8'h62};
      8'h21: {is_letter, lower} = {1'b1, 8'h63};
      8'h23: {is_letter, lower} = {1'b1, 8'h64};
      8'h24: {is_letter, lower} = {1'b1, 8'h65};
      8'h2B: {is_letter, lower} = {1'b1, 8'h66};
      8'h34: {is_letter, lower} = {1'b1, 8'h67};
      8'h33: {is_letter, lower} = {1'b1, 8'h68};
      8'h43: {is_letter, lower} = {1'b1, 8'h69};
      8'h3B: {is_letter, lower} = {1'b1, 8'h6A};
      8'h42: {is_letter, lower} = {1'b1, 8'h6B};
      8'h4B: {is_letter, lower} = {1'b1, 8'h6C};
      8'h3A: {is_letter, lower} = {1'b1, 8'h6D};
      8'h31: {is_letter, lower} = {1'b1, 8'h6E};
      8'h44: {is_letter, lower} = {1'b1, 8'h6F};
      8'h4D: {is_letter, lower} = {1'b1, 8'h70};
      8'h15: {is_letter, lower} = {1'b1, 8'h71};
      8'h2D: {is_letter, lower} = {1'b1, 8'h72};
      8'h1B: {is_letter, lower} = {1'b1, 8'h73};
      8'h2C: {is_letter, lower} = {1'b1, 8'h74};
      8'h3C: {is_letter, lower} = {1'b1, 8'h75};
      8'h2A: {is_letter, lower} = {1'b1, 8'h76};
      8'h1D: {is_letter, lower} = {1'b1, 8'h77};
      8'h22: {is_letter, lower} = {1'b1, 8'h78};
      8'h35: {is_letter, lower} = {1'b1, 8'h79};
      8'h1A: {is_letter, lower} = {1'b1, 8'h7A};
      8'h45: lower = 8'h30;
      8'h16: lower = 8'h31;
      8'h1E: lower = 8'h32;
      8'h26: lower = 8'h33;
      8'h25: lower = 8'h34;
      8'h2E: lower = 8'h35;
      8'h36: lower = 8'h36;
      8'h3D: lower = 8'h37;
      8'h3E: lower = 8'h38;
      8'h46: lower = 8'h39;
      SC_SPACE: lower = SP;
      SC_ENTER: lower = CR;
      SC_BKSP:  lower = BS;
      default: is_mapped = 1'b0;
    endcase
  end
  assign ascii = (caps && is_letter) ? lower - CASE_OFFSET : lower;
endmodule

// File: rtl/kb_ascii_reader.sv
// kb_ascii_reader: pops scan codes from the keyboard FIFO and presents ASCII on a valid/ready port
module kb_ascii_reader
  import kb_pkg::*;
#(
  parameter logic [7:0] CAPS_CODE     = SC_CAPS,
  parameter bit         EMIT_UNMAPPED = 1'b0,
  parameter logic [7:0] UNMAPPED_CHAR = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kb_buf_empty,
  input  logic [7:0] key_code,
  output logic       rd_key_code,
  output logic [7:0] ascii_data,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       caps_lock,
  output logic       unmapped_tick
);
  state_t state, state_n;
  logic [7:0] code_reg;
  logic caps_reg;
  logic [7:0] m_ascii;
  logic m_mapped, unused_letter;
  logic is_caps, emit;
  kb_scan2ascii u_xlate (
    .code(code_reg),
    .caps(caps_reg),
    .ascii(m_ascii),
    .is_mapped(m_mapped),
    .is_letter(unused_letter)
  );
  assign caps_lock = caps_reg;
  assign is_caps = code_reg == CAPS_CODE;
  assign emit = !is_caps && (m_mapped || EMIT_UNMAPPED);
  // next state plus the combinational pop strobe and drop tick
  always_comb begin
    state_n = state;
    rd_key_code = 1'b0;
    unmapped_tick = 1'b0;
    case (state)
      IDLE: begin
        rd_key_code = !kb_buf_empty && !reset;
        state_n = kb_buf_empty ? IDLE : XLATE;
      end
      XLATE: begin
        unmapped_tick = !reset && !is_caps && !m_mapped && !EMIT_UNMAPPED;
        state_n = emit ? HOLD : IDLE;
      end
      HOLD: state_n = ascii_ready ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  // code capture, caps toggle and output character handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      code_reg <= 8'h00;
      caps_reg <= 1'b0;
      ascii_data <= 8'h00;
      ascii_valid <= 1'b0;
    end else begin
      if (rd_key_code) code_reg <= key_code;
      if (state == XLATE && is_caps) caps_reg <= !caps_reg;
      if (state == XLATE && emit) begin
        ascii_data <= m_mapped ? m_ascii : {1'b0, UNMAPPED_CHAR[6:0]};
        ascii_valid <= 1'b1;
      end else if (state == HOLD && ascii_ready) ascii_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_kb_ascii_reader.sv
// tb_kb_ascii_reader: directed checks of scan-code popping, translation, caps and handshake
module tb_kb_ascii_reader;
  logic clk = 1'b0, reset = 1'b1, ascii_ready = 1'b1;
  logic kb_buf_empty = 1'b1, rd_key_code, ascii_valid, caps_lock, unmapped_tick;
  logic [7:0] key_code = 8'h00, ascii_data;
  logic empty_e = 1'b1, rd_e, valid_e, caps_e, tick_e;
  logic [7:0] key_e = 8'h00, data_e;
  logic [7:0] q[$], got[$], e_got[$];
  int total = 0, bad = 0, pops = 0, ticks = 0, vcnt = 0, ticks_e = 0;
  int p0, t0, v0;

  kb_ascii_reader dut (
    .clk(clk), .reset(reset), .kb_buf_empty(kb_buf_empty), .key_code(key_code),
    .rd_key_code(rd_key_code), .ascii_data(ascii_data), .ascii_valid(ascii_valid),
    .ascii_ready(ascii_ready), .caps_lock(caps_lock), .unmapped_tick(unmapped_tick)
  );
  kb_ascii_reader #(.EMIT_UNMAPPED(1'b1)) dut_e (
    .clk(clk), .reset(reset), .kb_buf_empty(empty_e), .key_code(key_e),
    .rd_key_code(rd_e), .ascii_data(data_e), .ascii_valid(valid_e),
    .ascii_ready(ascii_ready), .caps_lock(caps_e), .unmapped_tick(tick_e)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic upd();
    kb_buf_empty = (q.size() == 0);
    key_code = kb_buf_empty ? 8'h00 : q[0];
  endtask

  task automatic push(input logic [7:0] c);
    q.push_back(c);
    upd();
  endtask

  task automatic cyc();
    logic p, pe;
    @(negedge clk);
    p = rd_key_code;
    pe = rd_e;
    if (rd_key_code) pops++;
    if (ascii_valid) vcnt++;
    if (unmapped_tick) ticks++;
    if (tick_e) ticks_e++;
    if (ascii_valid && ascii_ready) got.push_back(ascii_data);
    if (valid_e && ascii_ready) e_got.push_back(data_e);
    @(posedge clk);
    #1;
    if (p && q.size() > 0) q.delete(0);
    if (pe) empty_e = 1'b1;
    upd();
    #1;
  endtask

  task automatic wait_got(input int n);
    for (int i = 0; i < 60 && got.size() < n; i++) cyc();
    chk("wait_got", got.size(), n);
  endtask

  function automatic int gv(input int i);
    return got.size() > i ? int'(got[i]) : 'hFFF;
  endfunction

  initial begin
    cyc();
    cyc();
    chk("rst_rd", rd_key_code, 0);
    chk("rst_valid", ascii_valid, 0);
    chk("rst_data", ascii_data, 0);
    chk("rst_caps", caps_lock, 0);
    chk("rst_tick", unmapped_tick, 0);
    reset = 1'b0;
    push(8'h1C);
    #1;
    chk("a_pop", rd_key_code, 1);
    cyc();
    chk("a_xlate_rd", rd_key_code, 0);
    chk("a_xlate_valid", ascii_valid, 0);
    cyc();
    chk("a_valid", ascii_valid, 1);
    chk("a_data", ascii_data, 8'h61);
    cyc();
    chk("a_clear", ascii_valid, 0);
    chk("a_pops", pops, 1);
    got.delete();
    push(8'h58); push(8'h1C); push(8'h58); push(8'h1C);
    cyc();
    cyc();
    chk("caps_on", caps_lock, 1);
    wait_got(1);
    chk("upper_a", gv(0), 8'h41);
    cyc();
    cyc();
    chk("caps_off", caps_lock, 0);
    wait_got(2);
    chk("lower_a", gv(1), 8'h61);
    chk("caps_no_out", got.size(), 2);
    got.delete();
    ascii_ready = 1'b0;
    push(8'h16); push(8'h1E);
    p0 = pops;
    for (int i = 0; i < 12; i++) cyc();
    chk("bp_valid", ascii_valid, 1);
    chk("bp_data", ascii_data, 8'h31);
    chk("bp_pops", pops - p0, 1);
    chk("bp_queued", q.size(), 1);
    ascii_ready = 1'b1;
    wait_got(2);
    chk("bp_first", gv(0), 8'h31);
    chk("bp_second", gv(1), 8'h32);
    got.delete();
    t0 = ticks;
    v0 = vcnt;
    push(8'h76);
    empty_e = 1'b0;
    key_e = 8'h76;
    for (int i = 0; i < 6; i++) cyc();
    chk("um_tick", ticks - t0, 1);
    chk("um_novalid", vcnt - v0, 0);
    chk("um_e_count", e_got.size(), 1);
    chk("um_e_data", e_got.size() > 0 ? int'(e_got[0]) : 'hFFF, 8'h00);
    chk("um_e_notick", ticks_e, 0);
    push(8'h58);
    cyc();
    cyc();
    chk("caps_on2", caps_lock, 1);
    push(8'h45); push(8'h5A); push(8'h66); push(8'h29);
    wait_got(4);
    chk("caps_0", gv(0), 8'h30);
    chk("caps_cr", gv(1), 8'h0D);
    chk("caps_bs", gv(2), 8'h08);
    chk("caps_sp", gv(3), 8'h20);
    push(8'h58);
    cyc();
    cyc();
    chk("caps_off2", caps_lock, 0);
    ascii_ready = 1'b0;
    push(8'h1A); push(8'h1C);
    for (int i = 0; i < 10 && !ascii_valid; i++) cyc();
    chk("hold_valid", ascii_valid, 1);
    chk("hold_data", ascii_data, 8'h7A);
    reset = 1'b1;
    cyc();
    chk("mr_valid", ascii_valid, 0);
    chk("mr_caps", caps_lock, 0);
    chk("mr_rd", rd_key_code, 0);
    reset = 1'b0;
    #1;
    chk("mr_pop", rd_key_code, 1);
    ascii_ready = 1'b1;
    got.delete();
    wait_got(1);
    chk("mr_next", gv(0), 8'h61);
    chk("mr_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/kb_ascii_reader.md
Name: kb_ascii_reader

Overview:
- Downstream consumer of the keyboard scan-code unit.
- Pops released-key scan codes from that unit's FIFO through its kb_buf_empty / rd_key_code / key_code interface.
- Translates PS/2 set-2 codes to 7-bit ASCII in an 8-bit field and tracks Caps Lock state.
- Presents each character on a valid/ready output port to the text/console logic.

Parameters:
- CAPS_CODE, 8'h58, scan code that toggles Caps Lock.
- EMIT_UNMAPPED, 0, 1: unmapped codes are emitted as UNMAPPED_CHAR. 0: unmapped codes are dropped.
- UNMAPPED_CHAR, 8'h00, character emitted for unmapped codes when EMIT_UNMAPPED=1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- kb_buf_empty  in  1  upstream FIFO empty flag.
- key_code  in  8  upstream FIFO head. Valid whenever kb_buf_empty=0, independent of rd_key_code.
- rd_key_code  out  1  one-cycle pop strobe to upstream FIFO.
- ascii_data  out  8  translated character, bit 7 always 0.
- ascii_valid  out  1  ascii_data holds an unconsumed character.
- ascii_ready  in  1  consumer accepts the character when ascii_valid=1.
- caps_lock  out  1  current Caps Lock state, for the keyboard LED or status.
- unmapped_tick  out  1  one-cycle pulse when an unmapped code is dropped.

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs go to 0 on the first clk edge with reset=1. Registered state clears to IDLE, code_reg=0, caps_reg=0. rd_key_code is 0 during reset.
- Reset mid-operation: a code already popped but not yet emitted is discarded, and a pending ascii_valid is dropped.
- FSM states: IDLE, XLATE, HOLD.
- IDLE: when kb_buf_empty=0, drive rd_key_code=1 combinationally for exactly this cycle, capture key_code into code_reg at the edge, and go to XLATE. Otherwise stay in IDLE with rd_key_code=0.
- XLATE: rd_key_code=0. One of four cases applies:
  - code_reg==CAPS_CODE: toggle caps_reg, go to IDLE, no output.
  - Mapped code: load ascii_data, set ascii_valid=1, go to HOLD.
  - Unmapped code with EMIT_UNMAPPED=0: pulse unmapped_tick for this cycle (combinational from XLATE), go to IDLE.
  - Unmapped code with EMIT_UNMAPPED=1: load UNMAPPED_CHAR, set ascii_valid=1, go to HOLD, no tick.
- HOLD: ascii_data and ascii_valid stay stable. On an edge where ascii_ready=1, clear ascii_valid and go to IDLE. No pops occur while in HOLD, so the upstream FIFO provides buffering and backpressure.
- Latency: pop in cycle N, ascii_valid high from cycle N+2. Maximum throughput is one character per 3 cycles when ascii_ready is held at 1.
- ascii_ready while ascii_valid=0 is ignored.
- Translation, lower case (ASCII values in hex):
  - 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m
  - 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z
  - digits: 45 '0', 16 '1', 1E '2', 26 '3', 25 '4', 2E '5', 36 '6', 3D '7', 3E '8', 46 '9'
  - 29 space 20, 5A CR 0D, 66 BS 08
- Case rule: when caps_reg=1, letters are emitted as upper case (lower-case value minus 20h). Digits and controls are unaffected.
- caps_lock output equals caps_reg and changes the cycle after XLATE for CAPS_CODE.
- An empty/non-empty change in the same cycle as a return to IDLE has no special handling; IDLE samples kb_buf_empty each cycle.

Decomposition:
- Shared package kb_pkg holds:
  - FSM state encoding (2-bit localparams).
  - Scan-code constants: SC_CAPS=8'h58, SC_ENTER=8'h5A, SC_BKSP=8'h66, SC_SPACE=8'h29.
  - ASCII constants: CR, BS, SP, and CASE_OFFSET=8'h20.
- Sub-module kb_scan2ascii: purely combinational. Inputs are code[7:0] and caps. Outputs are ascii[7:0], is_mapped, and is_letter. Holds the case table.
- kb_ascii_reader holds the FSM, registers, and handshake.

Test Plan:
- Reset then FIFO holding 1C with ascii_ready=1 -> rd_key_code pulses once, ascii_valid=1 two cycles later with ascii_data=8'h61, cleared the next cycle.
- Codes 58, 1C, 58, 1C -> outputs 8'h41 then 8'h61. caps_lock goes 1 then back to 0. No output for either 58.
- ascii_ready=0 for 10 cycles with codes 16 and 1E queued -> ascii_data=8'h31 held stable, no further rd_key_code pulses. Raise ready -> 8'h31 then 8'h32, in order.
- Code 8'h76 with EMIT_UNMAPPED=0 -> single-cycle unmapped_tick, no ascii_valid. With EMIT_UNMAPPED=1 -> ascii_data=8'h00, ascii_valid=1, no tick.
- Caps on, codes 45, 5A, 66, 29 -> 30, 0D, 08, 20, unchanged by caps.
- reset asserted while in HOLD with 8'h7A pending -> next cycle ascii_valid=0, caps_lock=0, state IDLE. The next queued code is popped normally after reset deasserts.
